// File: rtl/number_adder_serial.sv
// rtl/number_adder_serial.sv - multi-cycle chunked adder/subtractor with valid/ready handshakes
//
// Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk
// first, rippling the carry between chunks. The result is presented with the
// MSB carry-out (for sub: 1 = no borrow) and the signed overflow flag.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, aborts any operation
//   in_valid   operands/mode present        in_ready   block idle, will accept
//   a, b       WIDTH-bit operands           sub        0: a+b, 1: a-b
//   out_valid  result held on y/ovf         out_ready  downstream accepts result
//   y          {carry_out, sum[WIDTH-1:0]}  ovf        signed overflow of sum
module number_adder_serial #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   y,
  output logic             ovf
);

  localparam int STEPS = WIDTH / CHUNK;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_r, b_r, res_r, res_next, sum_ext;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [CHUNK:0]   chunk_sum;
  logic             last_step;
  logic             carry_into_msb;

  // Operands are shifted right each RUN cycle so the active chunk always sits
  // at bit 0; result bits enter from the top and end up in place after STEPS.
  assign chunk_sum = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry};
  assign sum_ext   = WIDTH'(chunk_sum[CHUNK-1:0]);
  assign res_next  = (res_r >> CHUNK) | (sum_ext << (WIDTH - CHUNK));
  assign last_step = (cnt == CNT_W'(STEPS - 1));

  // On the last chunk a_r/b_r bit CHUNK-1 is the original operand MSB, so the
  // carry into the MSB falls out of the MSB full-adder equation.
  assign carry_into_msb = res_next[WIDTH-1] ^ a_r[CHUNK-1] ^ b_r[CHUNK-1];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      y     <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_r   <= a_r >> CHUNK;
          b_r   <= b_r >> CHUNK;
          carry <= chunk_sum[CHUNK];
          res_r <= res_next;
          cnt   <= cnt + CNT_W'(1);
          if (last_step) begin
            y   <= {chunk_sum[CHUNK], res_next};
            ovf <= carry_into_msb ^ chunk_sum[CHUNK];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_number_adder_serial.sv
// tb/tb_number_adder_serial.sv - self-checking bench for number_adder_serial over four configurations
module tb_number_adder_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  localparam int N = 4;
  int w_of[N] = '{8, 8, 8, 32};
  int c_of[N] = '{2, 1, 8, 4};

  logic [N-1:0] in_valid  = '0;
  logic [N-1:0] in_ready;
  logic [N-1:0] sub_v     = '0;
  logic [N-1:0] out_valid;
  logic [N-1:0] out_ready = '1;
  logic [N-1:0] ovf_v;
  logic [31:0]  a_v[N];
  logic [31:0]  b_v[N];
  logic [8:0]   y0, y1, y2;
  logic [32:0]  y3;

  int errors = 0;
  int checks = 0;

  number_adder_serial #(.WIDTH(8), .CHUNK(2)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .sub(sub_v[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .y(y0), .ovf(ovf_v[0]));
  number_adder_serial #(.WIDTH(8), .CHUNK(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .sub(sub_v[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .y(y1), .ovf(ovf_v[1]));
  number_adder_serial #(.WIDTH(8), .CHUNK(8)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .sub(sub_v[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .y(y2), .ovf(ovf_v[2]));
  number_adder_serial #(.WIDTH(32), .CHUNK(4)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .a(a_v[3]), .b(b_v[3]), .sub(sub_v[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .y(y3), .ovf(ovf_v[3]));

  function automatic logic [63:0] y_of(int idx);
    case (idx)
      0:       return 64'(y0);
      1:       return 64'(y1);
      2:       return 64'(y2);
      default: return 64'(y3);
    endcase
  endfunction

  // Reference: plain integer arithmetic plus the signed sign rule.
  function automatic void model(int w, longint unsigned av, longint unsigned bv, bit s,
                                output logic [63:0] ye, output logic oe);
    longint unsigned mask, full, r;
    bit sa, sb, sr;
    mask = (64'd1 << w) - 1;
    av   = av & mask;
    bv   = bv & mask;
    full = s ? (av + ((~bv) & mask) + 1) : (av + bv);
    ye   = full & ((64'd1 << (w + 1)) - 1);
    r    = full & mask;
    sa   = av[w-1];
    sb   = bv[w-1];
    sr   = r[w-1];
    oe   = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one op on instance idx, measures latency and checks the result.
  // Returns at the negedge where out_valid is first seen high.
  task automatic run_op(int idx, logic [31:0] av, logic [31:0] bv, bit s, string tag);
    logic [63:0] ye;
    logic        oe;
    int          cyc;
    model(w_of[idx], 64'(av), 64'(bv), s, ye, oe);
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready[idx]), 64'd1);
    in_valid[idx] = 1'b1;
    a_v[idx]      = av;
    b_v[idx]      = bv;
    sub_v[idx]    = s;
    @(negedge clk);
    in_valid[idx] = 1'b0;
    cyc = 1;
    while (!out_valid[idx] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc - 1), 64'(w_of[idx] / c_of[idx]));
    check({tag, "_y"}, y_of(idx), ye);
    check({tag, "_ovf"}, 64'(ovf_v[idx]), 64'(oe));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_in_ready%0d", i), 64'(in_ready[i]), 64'd1);
      check($sformatf("reset_out_valid%0d", i), 64'(out_valid[i]), 64'd0);
      check($sformatf("reset_y%0d", i), y_of(i), 64'd0);
      check($sformatf("reset_ovf%0d", i), 64'(ovf_v[i]), 64'd0);
    end

    // Directed arithmetic cases on every configuration, with hard constants
    // for the 8-bit instances.
    for (int i = 0; i < N; i++) begin
      run_op(i, 32'hFF, 32'h01, 1'b0, $sformatf("carry%0d", i));
      if (i < 3) check($sformatf("carry_const%0d", i), y_of(i), 64'h100);
      run_op(i, 32'h7F, 32'h01, 1'b0, $sformatf("ovf_pos%0d", i));
      if (i < 3) check($sformatf("ovf_pos_const%0d", i), 64'(ovf_v[i]), 64'd1);
      run_op(i, 32'h80, 32'h80, 1'b0, $sformatf("ovf_neg%0d", i));
      run_op(i, 32'h05, 32'h07, 1'b1, $sformatf("sub_borrow%0d", i));
      if (i < 3) check($sformatf("sub_borrow_const%0d", i), y_of(i), 64'h0FE);
      run_op(i, 32'h80, 32'h01, 1'b1, $sformatf("sub_ovf%0d", i));
      if (i < 3) check($sformatf("sub_ovf_const%0d", i), y_of(i), 64'h17F);
      run_op(i, 32'h00, 32'h00, 1'b1, $sformatf("sub_zero%0d", i));
      run_op(i, 32'h7FFFFFFF, 32'h00000001, 1'b0, $sformatf("wide_ovf%0d", i));
    end

    // Backpressure: result must hold while out_ready is low.
    out_ready[0] = 1'b0;
    run_op(0, 32'h12, 32'h34, 1'b0, "bp");
    for (int k = 0; k < 5; k++) begin
      in_valid[0] = ~in_valid[0];
      a_v[0]      = $urandom;
      b_v[0]      = $urandom;
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid[0]), 64'd1);
      check("bp_in_ready", 64'(in_ready[0]), 64'd0);
      check("bp_y", y_of(0), 64'h046);
      check("bp_ovf", 64'(ovf_v[0]), 64'd0);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", 64'(out_valid[0]), 64'd0);
    check("bp_release_in_ready", 64'(in_ready[0]), 64'd1);

    // Reset in the middle of RUN (cnt=2).
    in_valid[0] = 1'b1;
    a_v[0] = 32'h55;
    b_v[0] = 32'h22;
    sub_v[0] = 1'b0;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_in_ready", 64'(in_ready[0]), 64'd1);
    check("rst_mid_out_valid", 64'(out_valid[0]), 64'd0);
    check("rst_mid_y", y_of(0), 64'd0);
    run_op(0, 32'h10, 32'h20, 1'b0, "after_rst");
    check("after_rst_const", y_of(0), 64'h030);

    // Randomized back-to-back operations against the reference.
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 20; k++) begin
        run_op(i, $urandom, $urandom, 1'($urandom_range(1, 0)), $sformatf("rand%0d_%0d", i, k));
      end
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
